// File: rtl/gpu_pkg.sv
// rtl/gpu_pkg.sv - shared types and codes for the func_unit issuer
package gpu_pkg;

    localparam logic [2:0] TYPE_LOAD = 3'b110;
    localparam logic [2:0] TYPE_END  = 3'b111;

    typedef struct packed {
        logic [7:0] reserved;
        logic [5:0] shammt;
        logic [4:0] rd;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] typ;
    } instr_word_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ISSUE,
        WAIT,
        RESULT
    } issuer_state_t;

endpackage

// File: rtl/instr_fifo.sv
// rtl/instr_fifo.sv - instruction word FIFO with wrap-bit full/empty detection
module instr_fifo #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic [31:0] wdata,
    input  logic        pop,
    output logic [31:0] rdata,
    output logic        full,
    output logic        empty
);

    localparam int AW = $clog2(DEPTH);

    logic [31:0] mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_push;
    logic        do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A pop frees the head slot in the same cycle, so a full FIFO can still accept
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/func_unit_issuer.sv
// rtl/func_unit_issuer.sv - sequences load, buffered instructions and END into one func_unit lane
module func_unit_issuer
    import gpu_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int LOAD_CYCLES = 1,
    parameter int HOLD_CYCLES = 1,
    parameter int TIMEOUT     = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [31:0] instr_data,
    output logic [2:0]  type_instruction,
    output logic [4:0]  regnum_1,
    output logic [4:0]  regnum_2,
    output logic [4:0]  dest_reg,
    output logic [5:0]  shammt,
    output logic        is_active,
    input  logic [31:0] final_result,
    input  logic        thread_complete,
    output logic        result_valid,
    input  logic        result_ready,
    output logic [31:0] result_data,
    output logic        busy,
    output logic        timeout_err
);

    localparam logic [15:0] LOAD_N    = 16'(LOAD_CYCLES);
    localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

    issuer_state_t state;
    logic [15:0]    load_cnt;
    logic [15:0]    hold_cnt;
    logic [15:0]    wait_cnt;
    logic [31:0]    fifo_rdata;
    logic           fifo_full;
    logic           fifo_empty;
    logic           pop;
    instr_word_t    head;
    logic [7:0]     unused_reserved;

    assign instr_ready     = !fifo_full;
    assign busy            = (state != IDLE);
    assign head            = instr_word_t'(fifo_rdata);
    assign unused_reserved = head.reserved;
    assign pop             = (state == ISSUE) && (hold_cnt == '0) && !fifo_empty;

    instr_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (instr_valid && instr_ready),
        .wdata (instr_data),
        .pop   (pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            type_instruction <= TYPE_END;
            regnum_1         <= '0;
            regnum_2         <= '0;
            dest_reg         <= '0;
            shammt           <= '0;
            is_active        <= 1'b0;
            result_valid     <= 1'b0;
            result_data      <= '0;
            timeout_err      <= 1'b0;
            load_cnt         <= '0;
            hold_cnt         <= '0;
            wait_cnt         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    type_instruction <= TYPE_END;
                    regnum_1         <= '0;
                    regnum_2         <= '0;
                    dest_reg         <= '0;
                    shammt           <= '0;
                    is_active        <= 1'b0;
                    if (start) begin
                        state       <= LOAD;
                        timeout_err <= 1'b0;
                        load_cnt    <= LOAD_N;
                        hold_cnt    <= '0;
                    end
                end
                LOAD: begin
                    type_instruction <= TYPE_LOAD;
                    is_active        <= 1'b1;
                    if (load_cnt <= 16'd1) state <= ISSUE;
                    else                   load_cnt <= load_cnt - 16'd1;
                end
                ISSUE: begin
                    if (hold_cnt != '0) begin
                        hold_cnt <= hold_cnt - 16'd1;
                    end else if (pop) begin
                        type_instruction <= head.typ;
                        regnum_1         <= head.rs1;
                        regnum_2         <= head.rs2;
                        dest_reg         <= head.rd;
                        shammt           <= head.shammt;
                        is_active        <= 1'b1;
                        hold_cnt         <= HOLD_LAST;
                        if (head.typ == TYPE_END) begin
                            state    <= WAIT;
                            wait_cnt <= '0;
                        end
                    end else begin
                        // Starved: keep the last fields but tell func_unit not to commit
                        is_active <= 1'b0;
                    end
                end
                WAIT: begin
                    is_active <= 1'b1;
                    if (thread_complete) begin
                        result_data  <= final_result;
                        result_valid <= 1'b1;
                        is_active    <= 1'b0;
                        state        <= RESULT;
                    end else if (wait_cnt == WAIT_LAST) begin
                        timeout_err  <= 1'b1;
                        result_data  <= '0;
                        result_valid <= 1'b1;
                        is_active    <= 1'b0;
                        state        <= RESULT;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                RESULT: begin
                    is_active <= 1'b0;
                    if (result_ready) begin
                        result_valid     <= 1'b0;
                        type_instruction <= TYPE_END;
                        regnum_1         <= '0;
                        regnum_2         <= '0;
                        dest_reg         <= '0;
                        shammt           <= '0;
                        state            <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/func_unit_issuer.md
Name: func_unit_issuer

Overview:
- Front-end sequencer that drives one func_unit thread lane. It takes the place of the hand-written stimulus that currently exercises func_unit.
- A host pushes encoded instruction words into a small internal FIFO. On `start` the issuer runs a fixed sequence:
  - drives the register-file load type for a fixed number of cycles;
  - issues each buffered instruction as type_instruction/regnum_1/regnum_2/dest_reg/shammt;
  - terminates with the END type;
  - waits for thread_complete, then returns final_result to the host over a valid/ready handshake.

Parameters:
- DEPTH, 8, instruction FIFO entries (power of 2, ≥2).
- LOAD_CYCLES, 1, cycles the LOAD type (3'b110) is held after start.
- HOLD_CYCLES, 1, cycles each issued instruction is held on the func_unit inputs (≥1).
- TIMEOUT, 256, max cycles waiting for thread_complete after END issue.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- start  in  1  begin a run; honoured only in IDLE
- instr_valid  in  1  host instruction word valid
- instr_ready  out  1  FIFO not full
- instr_data  in  32  [2:0] type, [7:3] rs1, [12:8] rs2, [17:13] rd, [23:18] shammt, [31:24] reserved (ignored)
- type_instruction  out  3  to func_unit
- regnum_1  out  5  to func_unit
- regnum_2  out  5  to func_unit
- dest_reg  out  5  to func_unit
- shammt  out  6  to func_unit
- is_active  out  1  to func_unit; low = bubble, func_unit commits nothing
- final_result  in  32  from func_unit
- thread_complete  in  1  from func_unit
- result_valid  out  1  result available to host
- result_ready  in  1  host accepts result
- result_data  out  32  captured final_result
- busy  out  1  high in every state except IDLE
- timeout_err  out  1  sticky; set on timeout, cleared by next accepted start

Behaviour:
- Reset (synchronous, active-high) has these effects:
  - FSM goes to IDLE and the FIFO is emptied.
  - type_instruction=3'b111 and all register/shamt fields are 0.
  - is_active=0, result_valid=0, result_data=0, busy=0, timeout_err=0.
- Reset mid-run aborts immediately, with no partial result.
- FIFO push occurs when instr_valid && instr_ready, and is allowed in any state.
- instr_ready = !full. Push when full is not possible.
- Simultaneous push and pop on a full FIFO are both honoured, and the count is unchanged.
- Pointers are log2(DEPTH) bits with an extra wrap bit. Full and empty are derived from the wrap bit.
- FSM states are IDLE, LOAD, ISSUE, WAIT, RESULT.
- IDLE: outputs are parked (type 3'b111, is_active=0). start → LOAD; timeout_err is cleared and the load counter is loaded.
- LOAD:
  - type_instruction=3'b110 and is_active=1 for exactly LOAD_CYCLES cycles.
  - The first LOAD cycle is the cycle after start is sampled.
  - Then → ISSUE.
- ISSUE, FIFO non-empty and hold counter = 0:
  - Pop one word. Its fields appear on the outputs the next cycle, with is_active=1.
  - The fields are held for HOLD_CYCLES cycles.
- ISSUE, FIFO empty at a pop opportunity: is_active=0 (bubble) and the previous fields are held. Wait in this state.
- A popped word with type 3'b111 is driven as END with is_active=1, and the FSM goes → WAIT. Words behind it stay in the FIFO for the next run.
- Types 3'b000–3'b101 are passed through opaque. The issuer does not interpret ALU semantics.
- A 3'b110 word in the FIFO is passed through as a re-load.
- WAIT:
  - Outputs are held at END, is_active=1, and a timeout counter increments.
  - thread_complete=1 → capture final_result into result_data, go → RESULT, set result_valid=1 on entry.
  - Counter reaching TIMEOUT without completion → timeout_err=1, result_data=0, result_valid=1, → RESULT.
  - thread_complete in the same cycle as the timeout expiry: completion wins.
- RESULT:
  - is_active=0.
  - result_valid and result_data are stable until result_valid && result_ready, then → IDLE with result_valid=0 the next cycle.
  - start in RESULT is ignored.
- thread_complete seen outside WAIT is ignored.

Decomposition:
- Package `gpu_pkg` holds:
  - localparam type codes TYPE_LOAD=3'b110 and TYPE_END=3'b111;
  - a packed struct `instr_word_t` for the 32-bit word layout;
  - enum `issuer_state_t` {IDLE, LOAD, ISSUE, WAIT, RESULT}.
- One sub-module, `instr_fifo` (parameter DEPTH, 32-bit, synchronous reset, push/pop/full/empty).
- The FSM, counters and output registers stay in func_unit_issuer.

Test Plan:
- Reset, then push 4 words, then start:
  - 2 cycles after start → type_instruction=3'b110;
  - next cycle → type 001/rs1=7/rs2=6/rd=8;
  - then 010/10/11/12;
  - then 011/14/15/16;
  - then END;
  - no cycle has is_active=0 between these.
- Hold END in WAIT for 3 cycles, then pulse thread_complete with final_result=32'h0000001D → result_valid=1, result_data=32'h1D, held until result_ready; IDLE the next cycle.
- Push 9 words with DEPTH=8 → instr_ready=0 after the 8th word. Start a run; the first pop re-asserts instr_ready and the 9th word is accepted.
- Start with an empty FIFO → LOAD, then is_active=0 bubbles. Push END 5 cycles later → END driven 1 cycle after the pop.
- With TIMEOUT=4, never assert thread_complete → timeout_err=1, result_valid=1, result_data=0. The next start clears timeout_err.
- Assert rst in ISSUE with 2 words still queued → next cycle: IDLE, FIFO empty, is_active=0, busy=0, type_instruction=3'b111.
